// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage MIPS pipeline.
// Tracks EX/MEM/WB destinations and drives registered EX operand-mux selects.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_id,
  output logic                  ex_bubble,
  output logic [CNT_W-1:0]      lu_stall_count
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_POSTWB = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  regwrite;
    logic                  memread;
  } entry_t;

  entry_t ex_q, mem_q, wb_q;
  entry_t id_entry;
  logic [1:0] sel_a_next, sel_b_next;
  logic       ex_load_hit;

  function automatic logic is_producer(input entry_t e);
    return e.valid && e.regwrite && (e.dest != '0);
  endfunction

  // Youngest matching producer wins; r0 and unused operands always read the regfile.
  function automatic logic [1:0] pick_sel(input logic [REG_ADDR_W-1:0] src,
                                          input logic rd_src,
                                          input entry_t ex_e,
                                          input entry_t mem_e,
                                          input entry_t wb_e);
    if (!rd_src || src == '0)                      return SEL_RF;
    if (is_producer(ex_e)  && ex_e.dest  == src)   return SEL_EXMEM;
    if (is_producer(mem_e) && mem_e.dest == src)   return SEL_MEMWB;
    if (is_producer(wb_e)  && wb_e.dest  == src)   return SEL_POSTWB;
    return SEL_RF;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ex_load_hit = 1'b0;
    if (id_valid && is_producer(ex_q) && ex_q.memread)
      ex_load_hit = (id_use_rs && id_rs == ex_q.dest) ||
                    (id_use_rt && id_rt == ex_q.dest);
    stall_id = ex_load_hit && !flush;

    id_entry          = '0;
    id_entry.valid    = id_valid && !flush && !stall_id;
    id_entry.dest     = id_dest;
    id_entry.regwrite = id_regwrite;
    id_entry.memread  = id_memread;

    sel_a_next = pick_sel(id_rs, id_use_rs, ex_q, mem_q, wb_q);
    sel_b_next = pick_sel(id_rt, id_use_rt, ex_q, mem_q, wb_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q           <= '0;
      mem_q          <= '0;
      wb_q           <= '0;
      fwd_a_sel      <= SEL_RF;
      fwd_b_sel      <= SEL_RF;
      ex_bubble      <= 1'b0;
      lu_stall_count <= '0;
    end else if (!hold) begin
      wb_q      <= mem_q;
      mem_q     <= ex_q;
      ex_q      <= id_entry;
      ex_bubble <= stall_id;
      fwd_a_sel <= id_entry.valid ? sel_a_next : SEL_RF;
      fwd_b_sel <= id_entry.valid ? sel_b_next : SEL_RF;
      if (stall_id && lu_stall_count != '1)
        lu_stall_count <= lu_stall_count + 1'b1;
    end
  end

endmodule
